// File: rtl/hazard_controller_if.sv
// Decode-side bundle between the ID/EX datapath and the hazard controller:
// decoded instruction attributes and stage results in, forward port and
// stall / mult-div handshake out.
`timescale 1ns/1ps
interface hazard_controller_if;
  logic        id_valid;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rs;
  logic        id_uses_rt;
  logic        id_wr_en;
  logic [4:0]  id_rd;
  logic        id_is_load;
  logic        id_is_md;
  logic        id_reads_hilo;
  logic [31:0] ex_result;
  logic [31:0] wb_result;
  logic [4:0]  fwd_ra;
  logic [31:0] fwd_rd;
  logic        stall;
  logic        md_start;
  logic        md_busy;

  // Datapath side: presents decode info and results, consumes controls.
  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_wr_en, id_rd,
    output id_is_load, id_is_md, id_reads_hilo, ex_result, wb_result,
    input  fwd_ra, fwd_rd, stall, md_start, md_busy
  );

  // Controller side.
  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_wr_en, id_rd,
    input  id_is_load, id_is_md, id_reads_hilo, ex_result, wb_result,
    output fwd_ra, fwd_rd, stall, md_start, md_busy
  );
endinterface

// File: rtl/hazard_controller.sv
// Hazard and forwarding controller for the 3-stage core. Keeps a small
// scoreboard of the EX and WB destinations, drives the single forward port,
// raises stall on load-use / forward conflicts / busy mult-div, and sequences
// the fixed-latency mult-div unit.
`timescale 1ns/1ps
module hazard_controller #(
  parameter int unsigned MD_LAT = 8
) (
  input logic               clk,
  input logic               rst_n,
  hazard_controller_if.slave hz
);

  typedef enum logic [0:0] {StIdle, StBusy} md_state_e;

  localparam logic [7:0] MdLatCnt = 8'(MD_LAT);

  // Scoreboard slots
  logic       ex_valid_q, ex_valid_d;
  logic       ex_wr_q, ex_wr_d;
  logic [4:0] ex_rd_q, ex_rd_d;
  logic       ex_load_q, ex_load_d;
  logic       ex_md_q, ex_md_d;
  logic       wb_valid_q, wb_valid_d;
  logic       wb_wr_q, wb_wr_d;
  logic [4:0] wb_rd_q, wb_rd_d;

  // Mult-div sequencer
  md_state_e  md_state_q, md_state_d;
  logic [7:0] md_cnt_q, md_cnt_d;
  logic       md_start_q, md_start_d;
  logic       md_busy;

  logic        rs_ex_hit, rs_wb_hit, rt_ex_hit, rt_wb_hit;
  logic        rs_need, rt_need;
  logic        load_use, conflict, md_hold;
  logic        stall;
  logic        issue;
  logic [4:0]  fwd_ra;
  logic [31:0] fwd_rd;

  assign md_busy = (md_state_q == StBusy);

  // Operand hazard detection and forward-port selection (purely combinational).
  always_comb begin
    rs_ex_hit = hz.id_uses_rs && ex_valid_q && ex_wr_q && (ex_rd_q == hz.id_rs) &&
                (hz.id_rs != 5'd0);
    rt_ex_hit = hz.id_uses_rt && ex_valid_q && ex_wr_q && (ex_rd_q == hz.id_rt) &&
                (hz.id_rt != 5'd0);
    // EX is younger, so an EX match hides any WB match for the same operand.
    rs_wb_hit = hz.id_uses_rs && !rs_ex_hit && wb_valid_q && wb_wr_q &&
                (wb_rd_q == hz.id_rs) && (hz.id_rs != 5'd0);
    rt_wb_hit = hz.id_uses_rt && !rt_ex_hit && wb_valid_q && wb_wr_q &&
                (wb_rd_q == hz.id_rt) && (hz.id_rt != 5'd0);
    rs_need   = rs_ex_hit || rs_wb_hit;
    rt_need   = rt_ex_hit || rt_wb_hit;

    load_use  = ex_load_q && (rs_ex_hit || rt_ex_hit);
    // Only one forward port: two different registers cannot both be bypassed.
    conflict  = rs_need && rt_need && (hz.id_rs != hz.id_rt);
    md_hold   = (hz.id_is_md || hz.id_reads_hilo) && md_busy;
    stall     = hz.id_valid && (load_use || conflict || md_hold);

    // fwd_ra and fwd_rd are zero together; the selector keys only on fwd_ra.
    fwd_ra = 5'd0;
    fwd_rd = 32'd0;
    if (rs_need) begin
      fwd_ra = hz.id_rs;
      fwd_rd = rs_ex_hit ? hz.ex_result : hz.wb_result;
    end else if (rt_need) begin
      fwd_ra = hz.id_rt;
      fwd_rd = rt_ex_hit ? hz.ex_result : hz.wb_result;
    end
  end

  assign issue       = hz.id_valid && !stall;
  assign hz.fwd_ra   = fwd_ra;
  assign hz.fwd_rd   = fwd_rd;
  assign hz.stall    = stall;
  assign hz.md_start = md_start_q;
  assign hz.md_busy  = md_busy;

  // Scoreboard advance: WB takes EX, EX takes decode or a bubble.
  always_comb begin
    wb_valid_d = ex_valid_q;
    wb_wr_d    = ex_wr_q;
    wb_rd_d    = ex_rd_q;
    ex_valid_d = issue;
    ex_wr_d    = issue && hz.id_wr_en;
    ex_rd_d    = issue ? hz.id_rd : 5'd0;
    ex_load_d  = issue && hz.id_is_load;
    ex_md_d    = issue && hz.id_is_md;
  end

  // Mult-div sequencing: start pulses while the md op sits in EX, busy counts MD_LAT cycles.
  always_comb begin
    md_state_d = md_state_q;
    md_cnt_d   = md_cnt_q;
    md_start_d = issue && hz.id_is_md;
    unique case (md_state_q)
      StIdle: begin
        if (md_start_d) begin
          md_state_d = StBusy;
          md_cnt_d   = MdLatCnt;
        end
      end
      StBusy: begin
        if (md_cnt_q <= 8'd1) begin
          md_state_d = StIdle;
          md_cnt_d   = 8'd0;
        end else begin
          md_cnt_d = md_cnt_q - 8'd1;
        end
      end
      default: begin
        md_state_d = StIdle;
        md_cnt_d   = 8'd0;
      end
    endcase
  end

  // State registers; reset aborts any mult-div operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q <= 1'b0;
      ex_wr_q    <= 1'b0;
      ex_rd_q    <= 5'd0;
      ex_load_q  <= 1'b0;
      ex_md_q    <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_wr_q    <= 1'b0;
      wb_rd_q    <= 5'd0;
      md_state_q <= StIdle;
      md_cnt_q   <= 8'd0;
      md_start_q <= 1'b0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_wr_q    <= ex_wr_d;
      ex_rd_q    <= ex_rd_d;
      ex_load_q  <= ex_load_d;
      ex_md_q    <= ex_md_d;
      wb_valid_q <= wb_valid_d;
      wb_wr_q    <= wb_wr_d;
      wb_rd_q    <= wb_rd_d;
      md_state_q <= md_state_d;
      md_cnt_q   <= md_cnt_d;
      md_start_q <= md_start_d;
    end
  end

  // md_start mirrors EX.md && EX.valid; ex_md_q is kept to make that pairing explicit.
  logic md_start_shadow;
  assign md_start_shadow = ex_md_q && ex_valid_q;
  always_comb begin
    if (md_start_shadow != md_start_q) begin
      // unreachable: both are loaded from the same issue decision
    end
  end

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline hazard and operand-forwarding controller for the 3-stage MIPS core (IF/ID, EX, WB). It tracks the destination registers of the instructions in EX and WB and drives the single forwarding port of the decode/EX operand selector (forward register address plus forward data). It stalls decode on load-use, forwarding-port conflicts and busy mult/div, and it sequences the fixed-latency mult/div unit with a start/busy pair.

## Interface
- MD_LAT, 8: mult/div latency in cycles; legal range 1..255.

- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  decode holds a real instruction.
- id_rs  in  5  decode source register A (Instruction[25:21]).
- id_rt  in  5  decode source register B (Instruction[20:16]).
- id_uses_rs  in  1  decode instruction reads rs.
- id_uses_rt  in  1  decode instruction reads rt.
- id_wr_en  in  1  decode instruction writes a GPR.
- id_rd  in  5  decode destination register.
- id_is_load  in  1  decode instruction is a load.
- id_is_md  in  1  decode instruction is mult/multu/div/divu.
- id_reads_hilo  in  1  decode instruction is mfhi/mflo.
- ex_result  in  32  ALU result of the instruction in EX.
- wb_result  in  32  writeback data in WB, including load data.
- fwd_ra  out  5  forward register address; 0 = no forward.
- fwd_rd  out  32  forward data.
- stall  out  1  hold PC and decode; inject a bubble into EX.
- md_start  out  1  one-cycle start to the mult/div unit.
- md_busy  out  1  mult/div result not yet valid.

## Operation
- Scoreboard registers:
  - EX slot: valid, wr, rd, load, md.
  - WB slot: valid, wr, rd.
- Advance every cycle:
  - WB ← EX.
  - EX ← decode when id_valid && !stall; otherwise EX ← bubble (valid=0).
- A slot matches register r when valid && wr && rd==r && r!=0. Register 0 is never forwarded. The register file does not bypass, so WB hits must be forwarded.
- Need per used operand (rs, rt):
  - EX match takes priority over WB match.
  - EX match with load=1 is a load-use hit.
- Forwarding output:
  - One forward needed, or both operands need the same register: fwd_ra = that register.
  - fwd_rd = ex_result on an EX hit, wb_result on a WB hit.
  - No forward: fwd_ra=0 and fwd_rd=0. Both must be 0 together because the selector compares fwd_ra to $0 without qualification.
- stall = id_valid && (load_use || conflict || md_hold).
  - load_use: any used operand hits an EX load.
  - conflict: rs and rt need forwards from different registers. One stall cycle resolves it, because the WB instruction retires to the register file.
  - md_hold: (id_is_md || id_reads_hilo) && md_busy.
- While stall is high, fwd_ra and fwd_rd are don't-care but must still follow the rules above.
- Mult/div FSM, IDLE → BUSY → IDLE:
  - md_start is registered. It is high for exactly the cycle an md instruction occupies EX (EX.md && EX.valid).
  - On md_start the FSM enters BUSY and the counter loads MD_LAT.
  - md_busy is high for exactly MD_LAT cycles, starting with the md_start cycle. The counter decrements each cycle and the FSM returns to IDLE when it expires.
- Simultaneous events: load_use, conflict and md_hold are ORed. Each rule clears independently, and the stall persists until all have cleared.

## Timing
- Reset (rst_n low, asynchronous):
  - Both slots become invalid; FSM goes to IDLE; counter = 0.
  - stall=0, fwd_ra=0, fwd_rd=0, md_start=0, md_busy=0.
  - The release edge is synchronous to clk.
  - Reset during BUSY aborts the operation; md_busy drops immediately.
- fwd_ra, fwd_rd and stall are combinational from the slots and the id_* inputs, and are valid in the same cycle as decode. They contain no flops on the id_* path to stall.
- Load-use costs exactly 1 stall cycle; the load is then in WB and is forwarded from wb_result.
- A forwarding conflict costs exactly 1 stall cycle.
- An md instruction decoded in cycle t:
  - is in EX at t+1, with md_start=1 and md_busy=1;
  - md_busy stays high through t+MD_LAT and is 0 at t+MD_LAT+1.
- A dependent md instruction or mfhi/mflo stalls through t+MD_LAT and issues at t+MD_LAT+1.
- Back-to-back md: the second md instruction stalls until md_busy=0. md_start never fires while md_busy=1 from a previous operation.

## Test plan
- Reset mid-BUSY:
  - MD_LAT=8; assert rst_n=0 three cycles after md_start.
  - Required: all outputs 0 asynchronously. After release, mfhi issues with no stall.
- EX forward:
  - addu $5 followed by addu $6,$5,$7, with ex_result=0x1234_5678.
  - Required: fwd_ra=5, fwd_rd=0x12345678, stall=0.
- Load-use:
  - lw $8 followed by addu $9,$8,$8.
  - Required: stall=1 for exactly 1 cycle. The next cycle gives fwd_ra=8, fwd_rd=wb_result.
- $0 and no-hazard:
  - addu $0 followed by addu $1,$0,$0.
  - Required: fwd_ra=0, fwd_rd=0, stall=0.
- Conflict:
  - Write $3 in WB and write $4 in EX; decode reads rs=$3 and rt=$4.
  - Required: stall 1 cycle. Then fwd_ra=4, fwd_rd=wb_result.
- Mult/div:
  - MD_LAT=4; mult in decode at cycle 0, mflo at cycle 1.
  - Required: md_start=1 at cycle 1 only. md_busy=1 for cycles 1–4. stall=1 for cycles 1–4. mflo issues at cycle 5.
